// File: rtl/layer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : layer_seq_pkg
// Brief  : Shared types and helpers for the time-multiplexed dense-layer
//          sequencer: state encoding, width helpers and ReLU/requantisation.
//          Build option: LAYER_SEQ_SAT_EN selects saturating 8-bit output;
//          when undefined the result wraps to its low 8 bits.
// Rev    : 1.0  initial release
// ============================================================================
package layer_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // $clog2 that never collapses to a zero-width vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sum of N_IN 16-bit products plus an 8-bit bias cannot overflow this.
    function automatic int acc_width(input int n_in);
        return 16 + $clog2(n_in + 1) + 1;
    endfunction

    // One ROM word per weight plus one bias word per node.
    function automatic int addr_width(input int n_in, input int n_out);
        return clog2_min1(n_out * (n_in + 1));
    endfunction

    // Negative sums clamp to zero, then scale down by the requant shift.
    function automatic logic [7:0] relu_requant(input logic signed [31:0] acc,
                                                input int                 shift);
        logic signed [31:0] r;
        r = acc[31] ? 32'sd0 : (acc >>> shift);
`ifdef LAYER_SEQ_SAT_EN
        return (r > 32'sd255) ? 8'hFF : 8'(r);
`else
        return 8'(r);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_mac_unit.sv
`default_nettype none
// ============================================================================
// Module : layer_mac_unit
// Brief  : Registered signed 8x8 multiply-accumulate with clear,
//          accumulate-product and accumulate-bias controls.
// Rev    : 1.0  initial release
// ============================================================================
module layer_mac_unit #(
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    acc_prod_i,
    input  logic                    acc_bias_i,
    input  logic [7:0]              act_i,
    input  logic [7:0]              w_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [15:0]      w_prod;
    logic signed [ACC_W-1:0] acc_q;

    assign w_prod = $signed(act_i) * $signed(w_i);
    assign acc_o  = acc_q;

    // Accumulator: clear dominates; product and bias are mutually exclusive.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            acc_q <= '0;
        end else if (acc_prod_i) begin
            acc_q <= acc_q + {{(ACC_W-16){w_prod[15]}}, w_prod};
        end else if (acc_bias_i) begin
            acc_q <= acc_q + {{(ACC_W-8){w_i[7]}}, w_i};
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : layer_mac_sequencer
// Brief  : Shares one signed 8x8 MAC across all nodes of a dense layer.
//          Buffers an activation vector, walks the weight/bias ROM node by
//          node, applies bias + ReLU + shift and hands results downstream one
//          node per handshake.
//          Build option: LAYER_SEQ_SAT_EN saturates out_data at 255 instead
//          of wrapping to the low byte.
// Rev    : 1.0  initial release
// ============================================================================
module layer_mac_sequencer
    import layer_seq_pkg::*;
#(
    parameter  int N_IN   = 15,
    parameter  int N_OUT  = 16,
    parameter  int SHIFT  = 0,
    localparam int AW     = addr_width(N_IN, N_OUT),
    localparam int ACC_W  = acc_width(N_IN),
    localparam int NODE_W = clog2_min1(N_OUT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_data_i,
    output logic              w_rd_en_o,
    output logic [AW-1:0]     w_addr_o,
    input  logic [7:0]        w_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        out_data_o,
    output logic [NODE_W-1:0] out_node_o,
    output logic              busy_o,
    output logic              layer_done_o
);

    // Counter k spans 0..N_IN+1 in MAC: N_IN+1 ROM issues then one drain.
    localparam int K_W    = clog2_min1(N_IN + 2);
    localparam int BUF_SZ = 2 ** K_W;

    state_e                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [NODE_W-1:0]       node_q, node_d;
    logic [AW-1:0]           base_q, base_d;
    logic                    rsp_valid_q;
    logic [K_W-1:0]          rsp_k_q;
    logic [7:0]              act_buf_q [BUF_SZ];
    logic                    act_we;
    logic                    mac_clr;
    logic                    rsp_is_bias;
    logic signed [ACC_W-1:0] acc;

    assign rsp_is_bias = (rsp_k_q == K_W'(N_IN));
    assign w_addr_o    = w_rd_en_o ? (base_q + AW'(k_q)) : '0;
    assign out_node_o  = node_q;
    assign out_data_o  = (state_q == ST_EMIT) ? relu_requant(32'(acc), SHIFT) : 8'd0;

    // Control registers; the ROM response tag trails each issue by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            k_q         <= '0;
            node_q      <= '0;
            base_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_k_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            node_q      <= node_d;
            base_q      <= base_d;
            rsp_valid_q <= w_rd_en_o;
            rsp_k_q     <= k_q;
        end
    end

    // Activation buffer write on each accepted input beat.
    always_ff @(posedge clk) begin
        if (act_we) begin
            act_buf_q[k_q] <= in_data_i;
        end
    end

    // Next-state and handshake outputs for LOAD / MAC / EMIT.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        node_d       = node_q;
        base_d       = base_q;
        act_we       = 1'b0;
        mac_clr      = 1'b0;
        in_ready_o   = 1'b0;
        w_rd_en_o    = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = 1'b1;
        layer_done_o = 1'b0;
        case (state_q)
            ST_LOAD: begin
                busy_o     = 1'b0;
                in_ready_o = 1'b1;
                mac_clr    = 1'b1;
                if (in_valid_i) begin
                    act_we = 1'b1;
                    if (k_q == K_W'(N_IN - 1)) begin
                        state_d = ST_MAC;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            ST_MAC: begin
                if (k_q <= K_W'(N_IN)) begin
                    w_rd_en_o = 1'b1;
                    k_d       = k_q + K_W'(1);
                end else begin
                    // Drain cycle: the bias response lands in the accumulator now.
                    state_d = ST_EMIT;
                    k_d     = '0;
                end
            end
            ST_EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    mac_clr = 1'b1;
                    if (node_q == NODE_W'(N_OUT - 1)) begin
                        layer_done_o = 1'b1;
                        state_d      = ST_LOAD;
                        node_d       = '0;
                        base_d       = '0;
                    end else begin
                        state_d = ST_MAC;
                        node_d  = node_q + NODE_W'(1);
                        base_d  = base_q + AW'(N_IN + 1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    layer_mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (mac_clr),
        .acc_prod_i (rsp_valid_q && !rsp_is_bias),
        .acc_bias_i (rsp_valid_q && rsp_is_bias),
        .act_i      (act_buf_q[rsp_k_q]),
        .w_i        (w_data_i),
        .acc_o      (acc)
    );

endmodule
`default_nettype wire

// File: tb/tb_layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_layer_mac_sequencer
// Brief  : Self-checking bench: directed and randomized layers against a
//          plain-arithmetic reference of the dense layer, plus a 1x1 SHIFT=2
//          instance for the degenerate size and requantisation cases.
// Rev    : 1.0  initial release
// ============================================================================
module tb_layer_mac_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int AW    = 4;
    localparam int NW    = 1;
    localparam int ROM_N = N_OUT * (N_IN + 1);
    localparam int TMO   = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic          in_valid, in_ready, w_rd_en, out_valid, out_ready, busy, layer_done;
    logic [7:0]    in_data, w_data, out_data;
    logic [AW-1:0] w_addr;
    logic [NW-1:0] out_node;

    logic       in_valid_s, in_ready_s, w_rd_en_s, out_valid_s, out_ready_s, busy_s, layer_done_s;
    logic [7:0] in_data_s, w_data_s, out_data_s;
    logic [0:0] w_addr_s, out_node_s;

    int checks   = 0;
    int failures = 0;
    int act_v [N_IN];
    logic signed [7:0] rom   [ROM_N];
    logic signed [7:0] rom_s [2];

    logic          req_en = 1'b0, req_en_s = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [0:0]    req_addr_s = '0;
    int addr_err = 0, beat_cnt = 0, rdy_busy_err = 0;

    layer_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(0)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .w_rd_en_o(w_rd_en), .w_addr_o(w_addr), .w_data_i(w_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_node_o(out_node), .busy_o(busy), .layer_done_o(layer_done)
    );

    layer_mac_sequencer #(.N_IN(1), .N_OUT(1), .SHIFT(2)) dut_s (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid_s), .in_ready_o(in_ready_s), .in_data_i(in_data_s),
        .w_rd_en_o(w_rd_en_s), .w_addr_o(w_addr_s), .w_data_i(w_data_s),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready_s), .out_data_o(out_data_s),
        .out_node_o(out_node_s), .busy_o(busy_s), .layer_done_o(layer_done_s)
    );

    // Sample DUT requests mid-cycle; the ROM answers one cycle after the read.
    always @(negedge clk) begin
        req_en     <= w_rd_en;
        req_addr   <= w_addr;
        req_en_s   <= w_rd_en_s;
        req_addr_s <= w_addr_s;
        if (w_rd_en && int'(w_addr) >= ROM_N) addr_err++;
        if (in_valid && in_ready) beat_cnt++;
        if (busy && in_ready) rdy_busy_err++;
    end

    always @(posedge clk) begin
        if (req_en)   w_data   <= rom[int'(req_addr)];
        if (req_en_s) w_data_s <= rom_s[int'(req_addr_s)];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: ReLU, arithmetic shift, then wrap or saturate to 8 bits.
    function automatic int requant(input longint acc, input int sh);
        longint r;
        r = (acc < 0) ? 0 : (acc >>> sh);
`ifdef LAYER_SEQ_SAT_EN
        return (r > 255) ? 255 : int'(r);
`else
        return int'(r % 256);
`endif
    endfunction

    function automatic int node_ref(input int n);
        longint acc = 0;
        for (int k = 0; k < N_IN; k++)
            acc += longint'(act_v[k]) * longint'(rom[n*(N_IN+1)+k]);
        acc += longint'(rom[n*(N_IN+1)+N_IN]);
        return requant(acc, 0);
    endfunction

    task automatic randomize_rom();
        for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic randomize_acts();
        for (int k = 0; k < N_IN; k++) act_v[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic load_vector(input bit hold);
        int t;
        for (int i = 0; i < N_IN; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(act_v[i]);
            t = 0;
            while (!in_ready && t < TMO) begin @(posedge clk); #1; t++; end
            if (t >= TMO) check("load_timeout", 32'(t), 0);
            @(posedge clk); #1;
        end
        if (!hold) in_valid = 1'b0;
        check("in_ready_after_load", 32'(in_ready), 0);
        check("busy_after_load", 32'(busy), 1);
    endtask

    task automatic run_nodes(input int stall_node, input int stall_cyc, input bit drop_valid);
        int t, bad, exp_d;
        for (int n = 0; n < N_OUT; n++) begin
            exp_d = node_ref(n);
            t = 0;
            while (!out_valid && t < TMO) begin @(posedge clk); #1; t++; end
            check("node_latency", 32'(t), N_IN + 2);
            check("out_node", 32'(out_node), n);
            check("out_data", 32'(out_data), exp_d);
            if (n == stall_node) begin
                bad = 0;
                for (int c = 0; c < stall_cyc; c++) begin
                    @(posedge clk); #1;
                    if (!out_valid || out_data !== 8'(exp_d) || out_node !== NW'(n) || w_rd_en)
                        bad++;
                end
                check("stall_stable", 32'(bad), 0);
            end
            out_ready = 1'b1;
            if (n == N_OUT - 1 && drop_valid) in_valid = 1'b0;
            #1;
            check("layer_done_at_hs", 32'(layer_done), 32'(n == N_OUT - 1));
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check("layer_done_after", 32'(layer_done), 0);
        check("busy_after_layer", 32'(busy), 0);
        check("in_ready_after_layer", 32'(in_ready), 1);
    endtask

    task automatic run_small(input int a, input int w, input int b);
        int t;
        rom_s[0] = 8'(w);
        rom_s[1] = 8'(b);
        in_valid_s = 1'b1;
        in_data_s  = 8'(a);
        t = 0;
        while (!in_ready_s && t < TMO) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        t = 0;
        while (!out_valid_s && t < TMO) begin @(posedge clk); #1; t++; end
        check("s_latency", 32'(t), 3);
        check("s_out_node", 32'(out_node_s), 0);
        check("s_out_data", 32'(out_data_s), requant(longint'(a) * longint'(w) + longint'(b), 2));
        out_ready_s = 1'b1;
        #1;
        check("s_layer_done", 32'(layer_done_s), 1);
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        check("s_busy_after", 32'(busy_s), 0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        in_valid_s = 1'b0; in_data_s = 8'd0; out_ready_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_node", 32'(out_node), 0);
        check("rst_w_rd_en", 32'(w_rd_en), 0);
        check("rst_w_addr", 32'(w_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_layer_done", 32'(layer_done), 0);
        check("rst_s_in_ready", 32'(in_ready_s), 1);

        // Directed: node0 sums to 10, node1 goes negative and clamps.
        for (int k = 0; k < N_IN; k++) act_v[k] = k + 1;
        for (int k = 0; k < N_IN; k++) begin rom[k] = 8'sd1; rom[N_IN+1+k] = -8'sd1; end
        rom[N_IN] = 8'sd0;
        rom[2*N_IN+1] = 8'sd2;
        load_vector(1'b0);
        run_nodes(-1, 0, 1'b0);

        // Largest positive sum on node0, with 20 cycles of backpressure.
        randomize_rom();
        for (int k = 0; k < N_IN; k++) begin act_v[k] = 127; rom[k] = 8'sd127; end
        rom[N_IN] = 8'sd127;
        load_vector(1'b0);
        run_nodes(0, 20, 1'b0);

        // Randomized layers with random stalls.
        for (int it = 0; it < 5; it++) begin
            randomize_rom();
            randomize_acts();
            load_vector(1'b0);
            run_nodes(int'($urandom_range(0, N_OUT - 1)), int'($urandom_range(0, 6)), 1'b0);
        end

        // in_valid held high for a whole layer: exactly N_IN beats consumed.
        begin
            int base_cnt;
            int d;
            randomize_rom();
            d = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < N_IN; k++) act_v[k] = d;
            base_cnt = beat_cnt;
            load_vector(1'b1);
            run_nodes(-1, 0, 1'b1);
            check("hold_beats", 32'(beat_cnt - base_cnt), N_IN);
        end

        // Reset in the middle of node1's MAC phase.
        randomize_rom();
        randomize_acts();
        load_vector(1'b0);
        t = 0;
        while (!out_valid && t < TMO) begin @(posedge clk); #1; t++; end
        check("pre_rst_node0_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_mac_rd_en", 32'(w_rd_en), 1);
        check("mid_mac_node", 32'(out_node), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_in_ready", 32'(in_ready), 1);
        check("mrst_w_rd_en", 32'(w_rd_en), 0);
        check("mrst_out_node", 32'(out_node), 0);

        // Partial vector discarded by reset, then a fresh full layer.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        randomize_rom();
        randomize_acts();
        load_vector(1'b0);
        run_nodes(-1, 0, 1'b0);

        // 1x1 layer, SHIFT=2: acc=10 -> 2, acc=-5 -> 0, then random.
        run_small(2, 4, 2);
        run_small(1, -5, 0);
        for (int it = 0; it < 3; it++)
            run_small(int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128);

        check("addr_in_range", 32'(addr_err), 0);
        check("in_ready_low_while_busy", 32'(rdy_busy_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
Time-multiplexed scheduler for one dense layer. It shares a single 8x8 signed MAC across N_OUT nodes instead of instantiating one node block per neuron. It buffers one input activation vector, walks a weight/bias ROM node by node, and applies bias and ReLU. Results are emitted one node per handshake to the next layer.

Parameters:
N_IN, 15, activations per vector / weights per node
N_OUT, 16, nodes in the layer
SHIFT, 0, arithmetic right shift applied after ReLU (requantisation)
AW, $clog2(N_OUT*(N_IN+1)), weight ROM address width (localparam)
ACC_W, 16+$clog2(N_IN+1)+1, accumulator width, overflow-free (localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  activation beat valid
in_ready  out  1  sequencer accepts activation
in_data  in  8  signed activation
w_rd_en  out  1  ROM read strobe
w_addr  out  AW  ROM address = node*(N_IN+1)+k; k==N_IN selects the bias
w_data  in  8  signed ROM data, valid 1 cycle after w_rd_en
out_valid  out  1  node result valid
out_ready  in  1  downstream accepts result
out_data  out  8  unsigned post-ReLU result
out_node  out  $clog2(N_OUT)  index of the node in out_data
busy  out  1  high in any state except LOAD
layer_done  out  1  1-cycle pulse on acceptance of the last node's result

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_node=0, w_rd_en=0, w_addr=0, busy=0, layer_done=0. State=LOAD; all counters and the accumulator clear.
- LOAD: in_ready=1. Each in_valid&in_ready beat writes act_buf[k], k++. The beat with k==N_IN-1 moves to MAC with node=0, k=0, acc=0. in_ready deasserts the following cycle.
- MAC: w_rd_en=1 and w_addr=node*(N_IN+1)+k for k=0..N_IN (N_IN+1 issues). Response pipelined by 1 cycle, with act index delayed to match:
  - response k<N_IN: acc += sext(act_buf[k]*w_data), 16-bit signed product;
  - response k==N_IN: acc += sext(w_data) (bias).
  - One drain cycle after the last issue, then EMIT. Per node: N_IN+2 cycles from MAC entry to out_valid.
- EMIT: r = (acc<0) ? 0 : acc>>>SHIFT; out_data = r[7:0] (see optional feature). out_valid is held with stable data until out_ready.
  - On handshake: if node<N_OUT-1, node++ and back to MAC with acc=0.
  - Otherwise pulse layer_done and return to LOAD.
- in_valid outside LOAD is ignored (in_ready=0). No beat is lost or duplicated at the LOAD->MAC edge.
- out_ready held low stalls indefinitely in EMIT; the ROM is not read while stalled.
- Reset mid-operation (any state): abort within the cycle, return to reset values, and discard the partial vector.
- N_IN==1 and N_OUT==1 must work. The address never exceeds N_OUT*(N_IN+1)-1.

Optional Feature:
LAYER_SEQ_SAT_EN
- defined: out_data = (r>255) ? 255 : r[7:0].
- undefined: out_data = r[7:0] (wrap, matching legacy node behaviour).

Decomposition:
- Package layer_seq_pkg: state enum (LOAD, MAC, EMIT), ACC_W/AW width functions, relu_requant function.
- One sub-module, layer_mac_unit: registered signed MAC with clear, accumulate-product and accumulate-bias controls.

Test Plan:
- N_IN=4, N_OUT=2, SHIFT=0. Acts 1,2,3,4; node0 weights 1,1,1,1, bias 0; node1 weights -1,-1,-1,-1, bias 2 -> out (node0,10), (node1,0); layer_done pulses once.
- Acts 127x4, weights 127x4, bias 127, node0 -> acc=64643; 255 with LAYER_SEQ_SAT_EN, 0x83 without.
- Backpressure: out_ready low 20 cycles in EMIT -> out_data stable, w_rd_en=0, no second node issued.
- in_valid held high across a full layer -> exactly N_IN beats consumed per layer; in_ready=0 while busy.
- Reset asserted mid-MAC of node1 -> next cycle state LOAD, out_valid=0, busy=0; a fresh vector gives correct results.
- SHIFT=2, acc=10 -> out_data=2; acc=-5 -> out_data=0.
